twobit_26x18_mesh: RTL and testbench
====================================

TWOBIT_26X18_MESH -- requirements
Module: twobit_26x18_mesh

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 inp  input  52  one row of 26 two-bit cells; column c = inp[2c+1:2c], c = 0..25.
REQ-005 row  input  5  target row index for a write, valid range 0..17.
REQ-006 high  input  1  phase select: 0 = load phase, 1 = evaluate phase.
REQ-007 out  output  468  evaluation result, one bit per cell; cell (r,c) = out[26r+c], r = 0..17, c = 0..25.

Function
REQ-008 Storage SHALL be an 18-row x 26-column array of 2-bit cells (936 bits).
REQ-009 Load: on a rising clk with rst_n=1 and high=0, the block SHALL write inp into row `row`, all 26 cells at once.
REQ-010 A write with row >= 18 SHALL be ignored; the array is unchanged.
REQ-011 While high=1, the block SHALL write nothing to the array.
REQ-012 A row written repeatedly SHALL hold the value from the last write.
REQ-013 Evaluation start SHALL be detected as high=1 on a rising clk after high=0 was sampled on the previous rising clk (edge T); a registered copy of high is used for this.
REQ-014 At edge T the block SHALL copy the whole array into a snapshot register; later writes do not affect that evaluation.
REQ-015 Cell rule, per bit: match(r,c) = 1 iff v(r,c) == 2'b11 (don't-care) or v(r,c) == v(r,(c+1) mod 26); column 25 compares against column 0 of the same row.
REQ-016 Processing pipeline:
- edge T: snapshot taken (stage 1);
- T+1: match bits computed and registered (stage 2);
- T+2: stage-3 register;
- T+3: out takes the match vector.
REQ-017 Required out timing:
- valid for exactly one clock cycle, from edge T+3 to edge T+4;
- at edge T+4, out SHALL return to all zeros;
- out SHALL be all zeros at every other time.
REQ-018 Holding high=1 SHALL NOT start another evaluation; a new evaluation needs high to return to 0 for at least one sampled edge.
REQ-019 If a new start is detected while an evaluation is in flight, both SHALL complete independently, each 4 edges after its own start, as a pipeline.
REQ-020 Simultaneous high=0 write and an in-flight evaluation: the write SHALL proceed, and the in-flight result SHALL use the old snapshot.

Reset
REQ-021 When rst_n=0 on a rising clk, the block SHALL clear the following to zero: all cells, the snapshot, all pipeline stages, the high-history register, and out.
REQ-022 Reset SHALL take priority over load and evaluation; a reset mid-evaluation aborts it, and no pulse appears afterwards.
REQ-023 After reset the array holds all 2'b00, so an evaluation with no loads yields out = all ones (every cell equals its neighbour).

Verification
REQ-024 Reset, then high=0, then write inp = 52'h5_5555_5555_5555 (all cells 01) to rows 0..17, then raise high -> out = all ones during the cycle after the 4th edge; all zeros before and after.
REQ-025 Alternating columns:
- stimulus: row 3 = 01 on even columns and 10 on odd columns, all other rows 00; then evaluate;
- response: out[103:78] = 0, and every other bit = 1.
REQ-026 Don't-care cells:
- stimulus: row 0 = 11 on columns 0..3 and 00 on columns 4..25;
- response: out[3:0] = 1 (11 acts as don't-care); out[4] = 1 (00 == 00); out[25] = 0 (00 vs column 0 = 11).
REQ-027 Write with row=20, then evaluate -> result identical to the evaluation before that write.
REQ-028 Hold high=1 for 20 cycles -> exactly one out pulse.
REQ-029 Reset at T+2 -> out stays zero with no pulse, and the array reads back all 00 on the next evaluation.

Source files
------------

// File: rtl/twobit_26x18_mesh.sv
// ---------------------------------------------------------------------------
// twobit_26x18_mesh
//
// Purpose:
//   18-row x 26-column array of 2-bit cells. Rows are loaded one at a time
//   while `high` is low. A rising edge of `high`, seen as high=1 now and
//   high=0 on the previous clock, captures the array into a snapshot. The
//   snapshot is then evaluated cell by cell against its right-hand
//   neighbour, which wraps from column 25 to column 0 of the same row. The
//   result is presented on `out` for exactly one cycle.
//
// Ports:
//   clk    in   1    rising-edge clock for all state
//   rst_n  in   1    synchronous active-low reset
//   inp    in   52   one row of 26 two-bit cells, column c = inp[2c+1:2c]
//   row    in   5    target row for a write (0..17; larger values ignored)
//   high   in   1    0 = load phase, 1 = evaluate phase
//   out    out  468  match bits, cell (r,c) = out[26r+c]
//
// Output protocol:
//   `out` has no separate valid strobe. It carries a result for exactly one
//   cycle, starting at the 4th rising edge after an evaluation start (the
//   start edge counts as the first). It is all zeros at every other time.
//   The consumer cannot stall the block (there is no ready), so every start
//   yields exactly one pulse unless a reset intervenes. Evaluations overlap
//   freely because each pipeline stage carries its own valid flag.
// ---------------------------------------------------------------------------
module twobit_26x18_mesh (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [51:0]  inp,
    input  logic [4:0]   row,
    input  logic         high,
    output logic [467:0] out
);

    localparam int ROWS = 18;
    localparam int COLS = 26;
    localparam int RW   = 2 * COLS;     // bits per row
    localparam int NB   = ROWS * COLS;  // result bits

    // Cell storage and the snapshot taken at the start of an evaluation.
    logic [RW-1:0] mem  [ROWS];
    logic [RW-1:0] snap [ROWS];

    // Registered copy of high, used to detect the rising edge of high.
    logic          high_q;
    logic          start;

    // Pipeline valid flags and data stages.
    logic          v1;          // snapshot holds a live evaluation
    logic          v2;          // match_q holds a live result
    logic          v3;          // stage3_q holds a live result
    logic [NB-1:0] match_c;     // combinational match vector from snapshot
    logic [NB-1:0] match_q;     // stage 2
    logic [NB-1:0] stage3_q;    // stage 3

    assign start = high && !high_q;

    // A cell matches when it is the don't-care code or equals its neighbour.
    function automatic logic cell_match(input logic [1:0] cur,
                                        input logic [1:0] nxt);
        return (cur == 2'b11) || (cur == nxt);
    endfunction

    // -----------------------------------------------------------------------
    // Array writes: only in the load phase. The row decode compares against
    // each legal row, so out-of-range row values write nothing.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) begin
                mem[r] <= '0;
            end
        end else if (!high) begin
            for (int r = 0; r < ROWS; r++) begin
                if (row == r[4:0]) begin
                    mem[r] <= inp;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage 1: high history and snapshot capture on an evaluation start.
    // The snapshot is only reloaded on a start, so writes made while an
    // evaluation is in flight never disturb it.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            high_q <= 1'b0;
            v1     <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                snap[r] <= '0;
            end
        end else begin
            high_q <= high;
            v1     <= start;
            if (start) begin
                for (int r = 0; r < ROWS; r++) begin
                    snap[r] <= mem[r];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Match computation from the snapshot. Column 25 wraps to column 0.
    // -----------------------------------------------------------------------
    always_comb begin
        match_c = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                match_c[r*COLS + c] = cell_match(
                    snap[r][2*c +: 2],
                    snap[r][2*((c + 1) % COLS) +: 2]);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stages 2 and 3, then the output register. The output is forced back
    // to zero whenever stage 3 holds nothing, which gives the one-cycle
    // pulse without any extra counter.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2       <= 1'b0;
            v3       <= 1'b0;
            match_q  <= '0;
            stage3_q <= '0;
            out      <= '0;
        end else begin
            v2       <= v1;
            v3       <= v2;
            match_q  <= v1 ? match_c : '0;
            stage3_q <= v2 ? match_q : '0;
            out      <= v3 ? stage3_q : '0;
        end
    end

endmodule

// File: tb/tb_twobit_26x18_mesh.sv
// ---------------------------------------------------------------------------
// tb_twobit_26x18_mesh
//
// Directed bench for twobit_26x18_mesh. Drivers load rows and raise high;
// each evaluation start pushes its hand-derived result and the cycle it is
// due into queues. A monitor on the falling edge compares `out` against
// the head of the queue on the due cycle and against zero on every other
// cycle.
// ---------------------------------------------------------------------------
module tb_twobit_26x18_mesh;

    localparam int NB = 468;

    // ---------------------------------------------------------------- clock/reset
    logic          clk;
    logic          rst_n;
    logic [51:0]   inp;
    logic [4:0]    row;
    logic          high;
    logic [NB-1:0] out;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    twobit_26x18_mesh dut (
        .clk   (clk),
        .rst_n (rst_n),
        .inp   (inp),
        .row   (row),
        .high  (high),
        .out   (out)
    );

    // Rising-edge count; drivers read it 1 time unit after an edge.
    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // ---------------------------------------------------------------- scoreboard
    logic [NB-1:0] exp_q[$];
    int            due_q[$];
    int            checks = 0;
    int            errors = 0;
    logic          mon_en = 1'b0;

    task automatic check(input string name, input logic [NB-1:0] act,
                         input logic [NB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (due_q.size() > 0 && due_q[0] < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_pulse cyc=%0d due=%0d", cyc, due_q[0]);
                void'(due_q.pop_front());
                void'(exp_q.pop_front());
            end
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                void'(due_q.pop_front());
                check("pulse", out, exp_q.pop_front());
            end else begin
                check("idle_zero", out, '0);
            end
        end
    end

    // ---------------------------------------------------------------- drivers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_row(input logic [4:0] r, input logic [51:0] d);
        high = 1'b0;
        row  = r;
        inp  = d;
        step();
    endtask

    // Raise high for one edge; the result is due 4 edges after the start.
    task automatic start_eval(input logic [NB-1:0] e);
        high = 1'b1;
        exp_q.push_back(e);
        due_q.push_back(cyc + 4);
        step();
    endtask

    task automatic evaluate(input logic [NB-1:0] e);
        start_eval(e);
        high = 1'b0;
        row  = 5'd31;
        step();
    endtask

    // All ones except the listed ranges of bits, which are cleared.
    function automatic logic [NB-1:0] ones_except(input int lo0, input int hi0,
                                                   input int lo1, input int hi1,
                                                   input int lo2, input int hi2);
        logic [NB-1:0] v;
        v = '1;
        for (int i = lo0; i <= hi0; i++) v[i] = 1'b0;
        for (int i = lo1; i <= hi1; i++) v[i] = 1'b0;
        for (int i = lo2; i <= hi2; i++) v[i] = 1'b0;
        return v;
    endfunction

    localparam logic [51:0] ALL01 = 52'h5_5555_5555_5555;
    localparam logic [51:0] ALT   = 52'h9_9999_9999_9999; // 01 even, 10 odd
    localparam logic [51:0] DC4   = 52'h0_0000_0000_00FF; // cols 0..3 = 11

    // Expected results, derived by hand from the cell rule.
    logic [NB-1:0] e_ones;
    logic [NB-1:0] e_alt3;   // row 3 alternating: row 3 all mismatch
    logic [NB-1:0] e_dc;     // row 0 don't-care: only bit 25 clears
    logic [NB-1:0] e_dc5;    // plus row 5 alternating
    logic [NB-1:0] e_dc57;   // plus row 7 alternating

    // ---------------------------------------------------------------- stimulus
    initial begin
        e_ones = ones_except(1, 0, 1, 0, 1, 0);
        e_alt3 = ones_except(78, 103, 1, 0, 1, 0);
        e_dc   = ones_except(25, 25, 1, 0, 1, 0);
        e_dc5  = ones_except(25, 25, 130, 155, 1, 0);
        e_dc57 = ones_except(25, 25, 130, 155, 182, 207);

        rst_n = 1'b0;
        high  = 1'b0;
        row   = 5'd0;
        inp   = '0;
        step();
        step();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        step();

        // Fresh array of 00 cells: every cell matches.
        evaluate(e_ones);

        // All cells 01.
        for (int r = 0; r < 18; r++) write_row(r[4:0], ALL01);
        evaluate(e_ones);

        // Row 3 alternating, everything else 00.
        for (int r = 0; r < 18; r++) write_row(r[4:0], '0);
        write_row(5'd3, ALT);
        evaluate(e_alt3);

        // Don't-care cells in row 0; row 3 back to 00.
        write_row(5'd3, '0);
        write_row(5'd0, DC4);
        evaluate(e_dc);

        // Out-of-range row writes leave the array unchanged.
        write_row(5'd20, ALT);
        write_row(5'd18, ALT);
        write_row(5'd31, ALT);
        evaluate(e_dc);

        // Two overlapping evaluations with a write between them: the first
        // uses the old snapshot, the second sees the new row 5.
        start_eval(e_dc);
        write_row(5'd5, ALT);
        start_eval(e_dc5);
        high = 1'b0;
        step();

        // Repeated writes to one row keep the last value.
        write_row(5'd7, ALL01);
        write_row(5'd7, ALT);
        evaluate(e_dc57);

        // Holding high for 20 cycles yields a single pulse.
        high = 1'b1;
        exp_q.push_back(e_dc57);
        due_q.push_back(cyc + 4);
        repeat (20) step();
        high = 1'b0;
        step();

        // Reset two edges after a start: no pulse, array cleared.
        high = 1'b1;
        step();
        step();
        rst_n = 1'b0;
        high  = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (6) step();
        evaluate(e_ones);

        // Drain pending results within a bounded number of cycles.
        for (int i = 0; i < 20 && due_q.size() > 0; i++) step();
        if (due_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout pending=%0d want=0", due_q.size());
        end
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
